kgp_imem_loader: RTL and testbench

Boot-time instruction-memory loader for the RISC_KGP core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words sequentially into instruction memory, checks an XOR checksum, and then releases the core from reset. It sits directly upstream of RISC_KGP: it feeds the instruction memory the core fetches from and drives the core's reset.

---
 rtl/kgp_imem_loader_pkg.sv | 22 ++
 rtl/kgp_imem_loader_if.sv | 24 ++
 rtl/kgp_imem_loader_assembler.sv | 29 ++
 rtl/kgp_imem_loader.sv | 117 +++++++++++
 tb/tb_kgp_imem_loader.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/kgp_imem_loader_pkg.sv
// kgp_loader_pkg: shared state encoding and stream-format constants for the imem loader
package kgp_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam int         HDR_LEN        = 2;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] CSUM_SEED      = 8'h00;

    // States in which the loader still consumes stream bytes
    function automatic logic is_loading(input state_t s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/kgp_imem_loader_if.sv
// kgp_imem_loader_if: byte-stream input, imem write port and core-control outputs of the loader
interface kgp_imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              load_done;
    logic              err;

    modport master (
        output in_valid, in_byte,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, err
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, err
    );
endinterface

// File: rtl/kgp_imem_loader_assembler.sv
// kgp_word_assembler: packs accepted bytes LSB-first into 32-bit words and flags each completed word
module kgp_word_assembler
    import kgp_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);
    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    // Only the three earlier bytes need storing; the fourth comes straight off the input
    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_en && (r_cnt == 2'(BYTES_PER_WORD - 1));

    // Shift accepted bytes in from the top so the first byte ends up in bits [7:0]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_en) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end
endmodule

// File: rtl/kgp_imem_loader.sv
// kgp_imem_loader: boot loader that streams a checksummed image into imem and releases RISC_KGP
module kgp_imem_loader
    import kgp_loader_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    kgp_imem_loader_if.slave  bus
);
    state_t            r_state;
    state_t            w_state_nx;
    logic [7:0]        r_n_lo;
    logic [15:0]       r_n;
    logic [15:0]       r_word_cnt;
    logic [7:0]        r_csum;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_core_rst;
    logic              r_done;
    logic              r_err;
    logic              w_xfer;
    logic              w_data_en;
    logic [15:0]       w_n_hdr;
    logic [31:0]       w_word;
    logic              w_word_valid;
    logic              w_last_word;

    assign w_xfer      = bus.in_valid && r_ready;
    assign w_data_en   = w_xfer && (r_state == ST_DATA);
    assign w_n_hdr     = {bus.in_byte, r_n_lo};
    assign w_last_word = w_word_valid && (r_word_cnt == r_n - 16'd1);

    kgp_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (w_data_en),
        .i_byte       (bus.in_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HDR0;
        else        r_state <= w_state_nx;
    end

    // Next state; oversize headers are rejected here so the address counter can never wrap
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_HDR0: if (w_xfer) w_state_nx = ST_HDR1;
            ST_HDR1: if (w_xfer) w_state_nx = (w_n_hdr > 16'(DEPTH)) ? ST_ERROR :
                                              (w_n_hdr == 16'd0)     ? ST_CSUM  : ST_DATA;
            ST_DATA: if (w_last_word) w_state_nx = ST_CSUM;
            ST_CSUM: if (w_xfer) w_state_nx = (bus.in_byte == r_csum) ? ST_RUN : ST_ERROR;
            default: w_state_nx = r_state;
        endcase
    end

    // Header length, running checksum over data bytes only, and completed-word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_lo     <= '0;
            r_n        <= '0;
            r_csum     <= CSUM_SEED;
            r_word_cnt <= '0;
        end else begin
            if (w_xfer && r_state == ST_HDR0) r_n_lo <= bus.in_byte;
            if (w_xfer && r_state == ST_HDR1) r_n <= w_n_hdr;
            if (w_data_en) r_csum <= r_csum ^ bus.in_byte;
            if (w_word_valid) r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    // Registered imem write port: one-cycle strobe after each word's fourth byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_word_valid;
            if (w_word_valid) begin
                r_addr  <= r_word_cnt[ADDR_W-1:0];
                r_wdata <= w_word;
            end
        end
    end

    // Status outputs follow the next state so they change on the edge the FSM moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready    <= 1'b0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ready    <= is_loading(w_state_nx);
            r_core_rst <= (w_state_nx != ST_RUN);
            r_done     <= (w_state_nx == ST_RUN);
            r_err      <= (w_state_nx == ST_ERROR);
        end
    end

    assign bus.in_ready   = r_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.core_rst   = r_core_rst;
    assign bus.load_done  = r_done;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_kgp_imem_loader.sv
// tb_kgp_imem_loader: directed-vector bench for the imem loader
module tb_kgp_imem_loader;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    kgp_imem_loader_if #(.ADDR_W(10)) bus ();

    kgp_imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          nwr = 0;
    int          last_wr_cyc = 0;
    int          t_first = 0;
    int          t_last = 0;
    logic [31:0] wr_addr [1100];
    logic [31:0] wr_data [1100];
    logic [7:0]  stream [$];
    logic [7:0]  nom [11] = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66};

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.imem_we) begin
            if (nwr < 1100) begin
                wr_addr[nwr] = 32'(bus.imem_addr);
                wr_data[nwr] = bus.imem_wdata;
            end
            nwr = nwr + 1;
            last_wr_cyc = cyc;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        nwr   = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int k;
        k = 0;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (!bus.in_ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            chk("send_ready", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send_stream(input int max_gap);
        foreach (stream[i]) begin
            send_byte(stream[i], max_gap);
            if (i == 0) t_first = cyc;
        end
        t_last = cyc;
    endtask

    task automatic load_nom();
        stream = {};
        foreach (nom[i]) stream.push_back(nom[i]);
    endtask

    task automatic chk_nominal(input string p);
        chk({p, "_nwr"},      32'(nwr), 32'd2);
        chk({p, "_addr0"},    wr_addr[0], 32'd0);
        chk({p, "_data0"},    wr_data[0], 32'h1122_3344);
        chk({p, "_addr1"},    wr_addr[1], 32'd1);
        chk({p, "_data1"},    wr_data[1], 32'hDEAD_BEEF);
        chk({p, "_core_rst"}, 32'(bus.core_rst), 32'd0);
        chk({p, "_done"},     32'(bus.load_done), 32'd1);
        chk({p, "_err"},      32'(bus.err), 32'd0);
        chk({p, "_ready"},    32'(bus.in_ready), 32'd0);
        chk({p, "_wr_first"}, 32'(last_wr_cyc < t_last), 32'd1);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_ready"},    32'(bus.in_ready), 32'd0);
        chk({p, "_we"},       32'(bus.imem_we), 32'd0);
        chk({p, "_addr"},     32'(bus.imem_addr), 32'd0);
        chk({p, "_wdata"},    bus.imem_wdata, 32'd0);
        chk({p, "_core_rst"}, 32'(bus.core_rst), 32'd1);
        chk({p, "_done"},     32'(bus.load_done), 32'd0);
        chk({p, "_err"},      32'(bus.err), 32'd0);
    endtask

    initial begin
        logic [7:0]  cs;
        logic [15:0] w;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        #1 chk("rst_rel_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 chk("rst_rel_ready_high", 32'(bus.in_ready), 32'd1);

        load_nom();
        send_stream(0);
        chk_nominal("nom");
        chk("nom_latency", 32'(t_last - t_first), 32'd10);

        do_reset();
        load_nom();
        stream[10] = 8'h67;
        send_stream(0);
        chk("bad_nwr",      32'(nwr), 32'd2);
        chk("bad_data1",    wr_data[1], 32'hDEAD_BEEF);
        chk("bad_err",      32'(bus.err), 32'd1);
        chk("bad_core_rst", 32'(bus.core_rst), 32'd1);
        chk("bad_done",     32'(bus.load_done), 32'd0);
        chk("bad_ready",    32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h66;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bad_ignore_nwr",  32'(nwr), 32'd2);
        chk("bad_ignore_err",  32'(bus.err), 32'd1);
        chk("bad_ignore_done", 32'(bus.load_done), 32'd0);

        do_reset();
        stream = {8'h00, 8'h00, 8'h00};
        send_stream(0);
        chk("empty_nwr",      32'(nwr), 32'd0);
        chk("empty_done",     32'(bus.load_done), 32'd1);
        chk("empty_core_rst", 32'(bus.core_rst), 32'd0);
        chk("empty_latency",  32'(t_last - t_first), 32'd2);

        do_reset();
        stream = {8'h01, 8'h04};
        send_stream(0);
        chk("over_err",      32'(bus.err), 32'd1);
        chk("over_ready",    32'(bus.in_ready), 32'd0);
        chk("over_core_rst", 32'(bus.core_rst), 32'd1);
        repeat (3) @(negedge clk);
        chk("over_nwr",      32'(nwr), 32'd0);

        do_reset();
        stream = {8'h00, 8'h04};
        cs = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            w = 16'(i);
            stream.push_back(w[7:0]);
            stream.push_back(w[15:8]);
            stream.push_back(8'h00);
            stream.push_back(8'h00);
            cs = cs ^ w[7:0] ^ w[15:8];
        end
        stream.push_back(cs);
        send_stream(0);
        chk("full_nwr",     32'(nwr), 32'd1024);
        chk("full_addr517", wr_addr[517], 32'd517);
        chk("full_data517", wr_data[517], 32'd517);
        chk("full_addr_last", wr_addr[1023], 32'd1023);
        chk("full_data_last", wr_data[1023], 32'd1023);
        chk("full_done",    32'(bus.load_done), 32'd1);
        chk("full_err",     32'(bus.err), 32'd0);

        do_reset();
        load_nom();
        send_stream(3);
        chk_nominal("gap");

        do_reset();
        for (int i = 0; i < 6; i++) send_byte(nom[i], 0);
        @(negedge clk);
        chk("mid_we_before", 32'(bus.imem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("mid");
        do_reset();
        load_nom();
        send_stream(0);
        chk_nominal("reload");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
